// File: rtl/led_frame_sequencer_if.sv
// led_frame_sequencer_if: frame request/qualifier inputs and per-slot outputs of the LED
// frame sequencer; master drives requests, slave (the sequencer) drives slot outputs.
interface led_frame_sequencer_if #(
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned STRAND_WIDTH   = 1,
   parameter int unsigned RAM_ADDR_WIDTH = 9
);
   logic                      frame_start;
   logic                      enable;
   logic                      direction;
   logic [ADDR_WIDTH-1:0]     led_index;
   logic [STRAND_WIDTH-1:0]   strand_select;
   logic [RAM_ADDR_WIDTH-1:0] ram_addr;
   logic                      led_selected;
   logic                      busy;
   logic                      frame_done;
   logic                      frame_overrun;

   modport master (
      output frame_start, enable, direction,
      input  led_index, strand_select, ram_addr, led_selected, busy, frame_done, frame_overrun
   );

   modport slave (
      input  frame_start, enable, direction,
      output led_index, strand_select, ram_addr, led_selected, busy, frame_done, frame_overrun
   );
endinterface

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: walks every LED of every strand once per frame, one slot per enabled tick.
// Define LED_SEQ_STRAND_GAP_EN to insert GAP_CYCLES idle slots between strands.
module led_frame_sequencer #(
   parameter int unsigned NUM_LEDS       = 150,
   parameter int unsigned NUM_STRANDS    = 2,
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned STRAND_WIDTH   = 1,
   parameter int unsigned RAM_ADDR_WIDTH = 9,
   parameter int unsigned GAP_CYCLES     = 4
) (
   input logic                  led_clock,
   input logic                  led_counter_reset,
   led_frame_sequencer_if.slave seq
);

`ifdef LED_SEQ_STRAND_GAP_EN
   localparam bit GapEn = 1'b1;
`else
   localparam bit GapEn = 1'b0;
`endif

   if (NUM_LEDS < 1 || NUM_STRANDS < 1 || 2**ADDR_WIDTH < NUM_LEDS ||
       2**STRAND_WIDTH < NUM_STRANDS || 2**RAM_ADDR_WIDTH < NUM_LEDS * NUM_STRANDS ||
       (GapEn && GAP_CYCLES < 1)) begin : g_bad_params
      $error("led_frame_sequencer: invalid parameter combination");
   end

   localparam logic [ADDR_WIDTH-1:0]   LastIdx    = ADDR_WIDTH'(NUM_LEDS - 1);
   localparam logic [STRAND_WIDTH-1:0] LastStrand = STRAND_WIDTH'(NUM_STRANDS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
`ifdef LED_SEQ_STRAND_GAP_EN
      StGap,
`endif
      StDone
   } state_e;

   state_e                    state_q, state_d;
   logic                      dir_q, dir_d;
   logic [ADDR_WIDTH-1:0]     idx_q, idx_d;
   logic [STRAND_WIDTH-1:0]   strand_q, strand_d;
   logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0]     start_idx;
   logic                      last_led;
   logic                      last_strand;

`ifdef LED_SEQ_STRAND_GAP_EN
   localparam int unsigned   GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
   logic [GapW-1:0] gap_q, gap_d;
`endif

   always_ff @(posedge led_clock or posedge led_counter_reset) begin
      if (led_counter_reset) begin
         state_q  <= StIdle;
         dir_q    <= 1'b0;
         idx_q    <= '0;
         strand_q <= '0;
         addr_q   <= '0;
`ifdef LED_SEQ_STRAND_GAP_EN
         gap_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         idx_q    <= idx_d;
         strand_q <= strand_d;
         addr_q   <= addr_d;
`ifdef LED_SEQ_STRAND_GAP_EN
         gap_q    <= gap_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      idx_d       = idx_q;
      strand_d    = strand_q;
`ifdef LED_SEQ_STRAND_GAP_EN
      gap_d       = gap_q;
`endif
      start_idx   = dir_q ? '0 : LastIdx;
      last_led    = dir_q ? (idx_q == LastIdx) : (idx_q == '0);
      last_strand = (strand_q == LastStrand);
      unique case (state_q)
         StIdle: begin
            if (seq.frame_start) begin
               state_d  = StRun;
               dir_d    = seq.direction;
               strand_d = '0;
               idx_d    = seq.direction ? '0 : LastIdx;
            end
         end
         StRun: begin
            if (seq.enable) begin
               if (!last_led) begin
                  idx_d = dir_q ? idx_q + ADDR_WIDTH'(1) : idx_q - ADDR_WIDTH'(1);
               end else if (!last_strand) begin
                  // Next strand is loaded now; in gap mode it stays hidden until GAP ends.
                  strand_d = strand_q + STRAND_WIDTH'(1);
                  idx_d    = start_idx;
`ifdef LED_SEQ_STRAND_GAP_EN
                  state_d  = StGap;
`endif
               end else begin
                  state_d = StDone;
               end
            end
         end
`ifdef LED_SEQ_STRAND_GAP_EN
         StGap: begin
            if (seq.enable) begin
               if (gap_q == GapLast) begin
                  gap_d   = '0;
                  state_d = StRun;
               end else begin
                  gap_d = gap_q + GapW'(1);
               end
            end
         end
`endif
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Address registered alongside index/strand so it never lags them.
      addr_d = RAM_ADDR_WIDTH'(32'(strand_d) * NUM_LEDS + 32'(idx_d));
   end

   always_comb begin
      seq.led_index     = idx_q;
      seq.strand_select = strand_q;
      seq.ram_addr      = addr_q;
      seq.led_selected  = (state_q == StRun);
`ifdef LED_SEQ_STRAND_GAP_EN
      seq.busy          = (state_q == StRun) || (state_q == StGap);
`else
      seq.busy          = (state_q == StRun);
`endif
      seq.frame_done    = (state_q == StDone);
      seq.frame_overrun = seq.frame_start && (state_q != StIdle);
   end

endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
Parametrised per-frame LED index sequencer for the LED actor. Once per frame it walks every LED on every strand and issues one index per enabled led_clock tick, with a flat RAM address for the colour buffer and a strand select for the xx6812 encoder mux. It supports a selectable scan direction and multi-strand operation, and signals frame completion and overrun with single-cycle pulses.

Parameters:
NUM_LEDS, 150, LEDs per strand (>=1)
NUM_STRANDS, 2, strands served in sequence per frame (>=1)
ADDR_WIDTH, 8, width of led_index; 2**ADDR_WIDTH >= NUM_LEDS
STRAND_WIDTH, 1, width of strand_select; 2**STRAND_WIDTH >= NUM_STRANDS
RAM_ADDR_WIDTH, 9, width of ram_addr; 2**RAM_ADDR_WIDTH >= NUM_LEDS*NUM_STRANDS
GAP_CYCLES, 4, inter-strand gap length; used only with the optional feature

Ports:
led_clock  input  1  sequencing clock, one LED slot per enabled rising edge
led_counter_reset  input  1  reset, asynchronous, active-high
frame_start  input  1  synchronous request to start a frame, sampled on the led_clock rising edge
enable  input  1  advance qualifier; low freezes all state, as during the framerate-high phase
direction  input  1  0 = descend NUM_LEDS-1..0, 1 = ascend 0..NUM_LEDS-1; captured at frame start
led_index  output  ADDR_WIDTH  current LED within the strand
strand_select  output  STRAND_WIDTH  current strand
ram_addr  output  RAM_ADDR_WIDTH  strand_select*NUM_LEDS + led_index
led_selected  output  1  high while led_index, strand_select and ram_addr are valid
busy  output  1  high from frame acceptance until frame_done
frame_done  output  1  single-cycle pulse at end of frame
frame_overrun  output  1  single-cycle pulse when frame_start arrives while not IDLE

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; captured direction 0.
- States: IDLE, RUN, GAP (optional feature only), DONE.
- IDLE: frame_start=1 -> RUN on the next edge, regardless of enable. In the same edge: capture direction; strand_select=0; led_index=0 (ascend) or NUM_LEDS-1 (descend); led_selected=1; busy=1. Latency from frame_start edge to first valid slot: 1 cycle.
- RUN, enable=0: hold every register.
- RUN, enable=1, not last LED of strand: step led_index by ±1.
- RUN, enable=1, last LED of a non-last strand: strand_select+1; led_index reloads to its start value. The next slot follows with no bubble.
- RUN, enable=1, last LED of last strand: -> DONE; led_selected=0; frame_done=1.
- DONE: lasts exactly 1 cycle, independent of enable. frame_done=1 and busy=0 in that cycle, then -> IDLE with frame_done=0.
- ram_addr is registered together with led_index and strand_select; it never presents a stale combination.
- No wrap-around: led_index stays within 0..NUM_LEDS-1, and strand_select never reaches NUM_STRANDS.
- frame_start in RUN, GAP or DONE: ignored; frame_overrun=1 for that cycle. A frame_start in DONE does not start a new frame.
- NUM_LEDS=1: every strand is one slot. NUM_STRANDS=1: the last-strand rule applies at strand 0.
- Direction changes during RUN have no effect until the next frame.
- Reset mid-frame aborts immediately: no frame_done pulse.

Optional Feature:
LED_SEQ_STRAND_GAP_EN
- Defined: after the last LED of a non-last strand (enable=1), enter GAP with led_selected=0 and busy=1. GAP counts GAP_CYCLES enabled cycles; enable=0 freezes the counter. Then return to RUN with the next strand's first LED.
- Undefined: no GAP state, no gap counter, GAP_CYCLES is ignored, and strands are back-to-back.

Test Plan:
- NUM_LEDS=4, NUM_STRANDS=2, direction=0, enable=1, frame_start pulse -> (strand,index,ram_addr) = (0,3,3),(0,2,2),(0,1,1),(0,0,0),(1,3,7),(1,2,6),(1,1,5),(1,0,4); then frame_done=1 for 1 cycle, busy low from that cycle.
- Same, direction=1 -> (0,0,0)..(0,3,3),(1,0,4)..(1,3,7); direction flipped mid-frame -> sequence unchanged.
- enable low for 3 cycles after slot (0,2) -> outputs held 3 cycles, then (0,1); total frame length 8+3 slots.
- frame_start at slot (1,1) and in the DONE cycle -> frame_overrun=1 each time, sequence unaffected, IDLE after DONE.
- led_counter_reset asserted between edges at slot (1,2) -> all outputs 0 immediately, no frame_done; next frame_start restarts at (0,3).
- With LED_SEQ_STRAND_GAP_EN, GAP_CYCLES=4 -> led_selected=0 for exactly 4 cycles between (0,0) and (1,3), busy stays 1.
